// File: rtl/chameleon_usart_pkg.sv
// Shared types and constants for the Chameleon serial receive path.
// Holds the FSM state encoding and the 8N1 framing levels.
package chameleon_usart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_t;

    localparam int   DATA_BITS   = 8;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/chameleon_sync_fifo.sv
// Generic synchronous first-word-fall-through FIFO with occupancy outputs.
// Latency: a pushed word is visible at pop_dat the cycle after the push.
// Backpressure: a push while full is accepted only with a same-cycle pop, otherwise ignored.
module chameleon_sync_fifo #(
    parameter int W  = 8,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic [W-1:0]  pop_dat,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   level,
    output logic [AW:0]   level_nxt
);

    localparam logic [AW:0] DEPTH = (AW+1)'(2**AW);

    logic [W-1:0]  mem_q [2**AW];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == DEPTH);
    assign level     = count_q;
    assign level_nxt = count_d;
    // Head is forced to zero while empty so the unreset storage never leaks out.
    assign pop_dat   = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat;
    end

endmodule

// File: rtl/chameleon_usart_rx.sv
// Synchronous 8N1 receiver (even parity when CHAMELEON_USART_RX_PARITY_EN is defined) into a FWFT FIFO.
// Latency: serial_clk rise to sample event 3 clk; stop-bit sample to rd_valid 1 clk.
// Backpressure: cts_n rises at CTS_THRESHOLD; bytes arriving while full are dropped with an overrun pulse.
module chameleon_usart_rx
    import chameleon_usart_pkg::*;
#(
    parameter int FIFO_AW        = 2,
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int CTS_THRESHOLD  = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               serial_clk,
    input  logic               serial_rxd,
    input  logic               rd_en,
    output logic [7:0]         rd_data,
    output logic               rd_valid,
    output logic [FIFO_AW:0]   level,
    output logic               cts_n,
    output logic               frame_err,
    output logic               overrun,
    output logic               timeout
);

    localparam int           TW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);
    localparam logic [2:0]   LAST_BIT = 3'(DATA_BITS - 1);

    logic sclk_s1_q, sclk_s2_q, sclk_prev_q, se_q;
    logic rxd_s1_q, rxd_s2_q, rxd_q;

    rx_state_t              state_q, state_d;
    logic [2:0]             bitcnt_q, bitcnt_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_q, overrun_d;
    logic                   timeout_q, timeout_d;
    logic                   cts_n_q, cts_n_d;
    logic                   fifo_push, fifo_pop, fifo_empty, fifo_full;
    logic [FIFO_AW:0]       fifo_level_nxt;
`ifdef CHAMELEON_USART_RX_PARITY_EN
    logic                   parity_err_q, parity_err_d;
`endif

    // Synchronisers idle high so a held-high line never looks like a start bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_s1_q   <= 1'b1;
            sclk_s2_q   <= 1'b1;
            sclk_prev_q <= 1'b1;
            rxd_s1_q    <= 1'b1;
            rxd_s2_q    <= 1'b1;
            rxd_q       <= 1'b1;
            se_q        <= 1'b0;
        end else begin
            sclk_s1_q   <= serial_clk;
            sclk_s2_q   <= sclk_s1_q;
            sclk_prev_q <= sclk_s2_q;
            rxd_s1_q    <= serial_rxd;
            rxd_s2_q    <= rxd_s1_q;
            rxd_q       <= rxd_s2_q;
            se_q        <= sclk_s2_q & ~sclk_prev_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        shreg_d     = shreg_q;
        timer_d     = timer_q;
        fifo_push   = 1'b0;
        frame_err_d = 1'b0;
        timeout_d   = 1'b0;
`ifdef CHAMELEON_USART_RX_PARITY_EN
        parity_err_d = parity_err_q;
`endif
        if (state_q == ST_IDLE || se_q) timer_d = '0;
        else if (timer_q != TMAX)       timer_d = timer_q + 1'b1;

        // A real edge wins over an expiring timer in the same cycle.
        if (se_q) begin
            case (state_q)
                ST_IDLE: begin
                    if (rxd_q == START_LEVEL) begin
                        state_d  = ST_DATA;
                        bitcnt_d = '0;
                    end
                end
                ST_DATA: begin
                    shreg_d  = {rxd_q, shreg_q[DATA_BITS-1:1]};
                    bitcnt_d = bitcnt_q + 1'b1;
                    if (bitcnt_q == LAST_BIT) begin
`ifdef CHAMELEON_USART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
`ifdef CHAMELEON_USART_RX_PARITY_EN
                ST_PARITY: begin
                    parity_err_d = ^{shreg_q, rxd_q};
                    state_d      = ST_STOP;
                end
`endif
                ST_STOP: begin
                    state_d = ST_IDLE;
`ifdef CHAMELEON_USART_RX_PARITY_EN
                    if (rxd_q == STOP_LEVEL && !parity_err_q) fifo_push   = 1'b1;
`else
                    if (rxd_q == STOP_LEVEL)                  fifo_push   = 1'b1;
`endif
                    else                                      frame_err_d = 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE && timer_q == TMAX) begin
            timeout_d = 1'b1;
            state_d   = ST_IDLE;
        end

        fifo_pop  = rd_en & ~fifo_empty;
        overrun_d = fifo_push & fifo_full & ~fifo_pop;
        cts_n_d   = (fifo_level_nxt >= (FIFO_AW+1)'(CTS_THRESHOLD));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            bitcnt_q    <= '0;
            shreg_q     <= '0;
            timer_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            timeout_q   <= 1'b0;
            cts_n_q     <= 1'b0;
`ifdef CHAMELEON_USART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            shreg_q     <= shreg_d;
            timer_q     <= timer_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            timeout_q   <= timeout_d;
            cts_n_q     <= cts_n_d;
`ifdef CHAMELEON_USART_RX_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    chameleon_sync_fifo #(
        .W  (DATA_BITS),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_dat  (shreg_q),
        .pop       (rd_en),
        .pop_dat   (rd_data),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .level     (level),
        .level_nxt (fifo_level_nxt)
    );

    assign rd_valid  = ~fifo_empty;
    assign cts_n     = cts_n_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_chameleon_usart_rx.sv
// Directed bench for chameleon_usart_rx: serial frames at clk/16 with a byte scoreboard.
module tb_chameleon_usart_rx;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       serial_clk;
    logic       serial_rxd;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [2:0] level;
    logic       cts_n;
    logic       frame_err;
    logic       overrun;
    logic       timeout;

    int vectors = 0;
    int miscompares = 0;
    int fe_cnt = 0, ov_cnt = 0, to_cnt = 0, multi_cnt = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    chameleon_usart_rx #(
        .FIFO_AW        (2),
        .TIMEOUT_CYCLES (1023),
        .CTS_THRESHOLD  (3)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .serial_clk (serial_clk),
        .serial_rxd (serial_rxd),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .level      (level),
        .cts_n      (cts_n),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .timeout    (timeout)
    );

    always @(negedge clk) begin
        if (frame_err) fe_cnt++;
        if (overrun)   ov_cnt++;
        if (timeout)   to_cnt++;
        if ((frame_err && overrun) || (frame_err && timeout) || (overrun && timeout)) multi_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // mode 0: plain; 1: check push latency on last bit; 2: pop in the exact push cycle.
    task automatic send_bits(input logic [11:0] bits, input int n, input int mode);
        logic [7:0] e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            serial_clk = 1'b0;
            serial_rxd = bits[i];
            repeat (8) @(negedge clk);
            serial_clk = 1'b1;
            if (i == n - 1 && mode != 0) begin
                repeat (3) @(negedge clk);
                if (mode == 1) check("lat_before_push", rd_valid, 0);
                if (mode == 2) begin
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                    check("simul_pop_data", rd_data, e);
                    rd_en = 1'b1;
                end
                @(negedge clk);
                rd_en = 1'b0;
                if (mode == 1) check("lat_push_valid", rd_valid, 1);
                repeat (4) @(negedge clk);
            end else begin
                repeat (7) @(negedge clk);
            end
        end
        serial_rxd = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input bit expect_push, input int mode);
        logic [11:0] bits;
        int n;
`ifdef CHAMELEON_USART_RX_PARITY_EN
        bits = {1'b0, stop, ^b, b, 1'b0};
        n = 11;
`else
        bits = {2'b00, stop, b, 1'b0};
        n = 10;
`endif
        if (expect_push) exp_q.push_back(b);
        send_bits(bits, n, mode);
    endtask

    task automatic pop_check(input string tag);
        logic [7:0] e;
        check({tag, "_valid"}, rd_valid, 1);
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_data"}, rd_data, e);
        end
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    initial begin
        int fe0, ov0, to0, waited;
        reset_n    = 1'b0;
        serial_clk = 1'b1;
        serial_rxd = 1'b1;
        rd_en      = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_level", level, 0);
        check("rst_cts_n", cts_n, 0);
        check("rst_pulses", {frame_err, overrun, timeout}, 0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // Single byte with exact push latency, then pop.
        send_frame(8'hA5, 1'b1, 1'b1, 1);
        check("a5_level", level, 1);
        pop_check("a5");
        check("a5_empty_valid", rd_valid, 0);
        check("a5_empty_level", level, 0);

        // Bad stop bit, then a good byte.
        fe0 = fe_cnt;
        send_frame(8'h3C, 1'b0, 1'b0, 0);
        check("fe_pulse_count", fe_cnt - fe0, 1);
        check("fe_level", level, 0);
        send_frame(8'h11, 1'b1, 1'b1, 0);
        pop_check("after_fe");

        // rd_en on an empty FIFO is ignored.
        rd_en = 1'b1;
        repeat (2) @(negedge clk);
        rd_en = 1'b0;
        check("underflow_level", level, 0);
        check("underflow_valid", rd_valid, 0);

        // Fill past full: cts_n at threshold, overrun on the 5th byte.
        ov0 = ov_cnt;
        send_frame(8'h01, 1'b1, 1'b1, 0);
        send_frame(8'h02, 1'b1, 1'b1, 0);
        check("cts_at_2", cts_n, 0);
        send_frame(8'h03, 1'b1, 1'b1, 0);
        check("cts_at_3", cts_n, 1);
        send_frame(8'h04, 1'b1, 1'b1, 0);
        check("full_level", level, 4);
        send_frame(8'h05, 1'b1, 1'b0, 0);
        check("overrun_count", ov_cnt - ov0, 1);
        check("overrun_level", level, 4);
        for (int i = 0; i < 4; i++) pop_check("drain");
        check("drain_level", level, 0);
        check("drain_cts", cts_n, 0);

        // Full FIFO with a pop in the exact push cycle: no overrun.
        for (int b = 1; b <= 4; b++) send_frame(8'(b), 1'b1, 1'b1, 0);
        ov0 = ov_cnt;
        send_frame(8'h05, 1'b1, 1'b1, 2);
        check("simul_no_overrun", ov_cnt - ov0, 0);
        check("simul_level", level, 4);
        for (int i = 0; i < 4; i++) pop_check("simul_drain");
        check("simul_drain_level", level, 0);

        // Serial clock stops after the 4th data bit.
        to0 = to_cnt;
        send_bits(12'b0000_0000_1010, 5, 0);
        waited = 0;
        while (waited < 2000 && to_cnt == to0) begin
            @(negedge clk);
            waited++;
        end
        check("timeout_seen", to_cnt - to0, 1);
        check("timeout_not_early", (waited >= 1000) ? 1 : 0, 1);
        repeat (3) @(negedge clk);
        check("timeout_width", to_cnt - to0, 1);
        check("timeout_level", level, 0);
        send_frame(8'h7E, 1'b1, 1'b1, 0);
        pop_check("after_timeout");

        // Mid-frame reset with a byte in the FIFO.
        send_frame(8'h42, 1'b1, 1'b1, 0);
        check("pre_reset_level", level, 1);
        send_bits(12'b0000_0000_0000, 5, 0);
        reset_n = 1'b0;
        #1;
        check("async_rst_valid", rd_valid, 0);
        check("async_rst_level", level, 0);
        check("async_rst_data", rd_data, 0);
        check("async_rst_cts", cts_n, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        send_bits(12'b0000_0001_1111, 5, 0);
        repeat (4) @(negedge clk);
        check("rst_tail_no_push", level, 0);
        send_frame(8'h5A, 1'b1, 1'b1, 0);
        pop_check("after_reset");

        check("pulse_exclusive", multi_cnt, 0);
        check("sb_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/chameleon_usart_rx.md
Name: chameleon_usart_rx

Overview:
- Synchronous serial receiver for the link from the Chameleon microcontroller to the FPGA: serial clock on usart_clk, data on usart_tx.
- It is the receive-direction counterpart of the reconfigure transmitter, which drives usart_rx.
- Deserialises 8N1 frames clocked by the external serial clock and buffers bytes in a small first-word-fall-through FIFO.
- Provides flow-control and error reporting to a host-side consumer, such as a cfide register port, in the sysclk domain.

Parameters:
- FIFO_AW, 2: FIFO depth is 2**FIFO_AW entries (default 4).
- TIMEOUT_CYCLES, 1023: clk cycles with no serial_clk rising edge, mid-frame, before the frame is aborted.
- CTS_THRESHOLD, 3: FIFO level at or above which cts_n deasserts (goes high).

Ports:
- clk, in, 1: system clock (sysclk).
- reset_n, in, 1: asynchronous active-low reset.
- serial_clk, in, 1: external serial clock; asynchronous to clk.
- serial_rxd, in, 1: serial data; sampled on serial_clk rising edge.
- rd_en, in, 1: pop request; honoured only when rd_valid=1.
- rd_data, out, 8: FIFO head byte; valid while rd_valid=1.
- rd_valid, out, 1: FIFO not empty.
- level, out, FIFO_AW+1: current FIFO occupancy.
- cts_n, out, 1: 0 = ready to receive; 1 when level >= CTS_THRESHOLD.
- frame_err, out, 1: one-cycle pulse when a stop bit is sampled as 0.
- overrun, out, 1: one-cycle pulse when a complete byte is dropped because the FIFO is full.
- timeout, out, 1: one-cycle pulse when a frame is aborted by TIMEOUT_CYCLES.

Behaviour:
- Reset: all outputs 0 except cts_n=0. FIFO empty, level=0, FSM in IDLE, synchronisers cleared to 1 (idle line).
- Input path:
  - serial_clk and serial_rxd each pass through a 2-FF synchroniser, then an edge register.
  - A sample event (se) is a 0->1 transition of the synchronised serial_clk.
  - Data is taken from the synchronised serial_rxd in the same cycle as se.
  - Latency from serial_clk pin rising to se is 3 clk cycles.
- FSM states: IDLE, DATA, PARITY (only when the optional feature is compiled in), STOP.
  - IDLE: on se with rxd=0 (start bit), go to DATA with bitcnt=0. On se with rxd=1, stay in IDLE.
  - DATA: on se, shift rxd into shreg LSB-first (shreg <= {rxd, shreg[7:1]}) and increment bitcnt (3 bits). On se with bitcnt=7, go to STOP (or PARITY).
  - STOP: on se with rxd=1, push shreg and go to IDLE. On se with rxd=0, pulse frame_err, discard the byte, go to IDLE.
- Timeout:
  - The timer clears on every se and while in IDLE.
  - When the timer reaches TIMEOUT_CYCLES in any non-IDLE state: pulse timeout, discard partial data, go to IDLE.
  - The timer saturates and never wraps.
- Push timing: the byte appears at rd_data with rd_valid=1 in the cycle after the STOP-state se (1-cycle push latency).
- FIFO:
  - Read pointer, write pointer and count; pointers wrap modulo 2**FIFO_AW.
  - Pop occurs when rd_en && rd_valid. rd_en while empty is ignored, with no underflow and no pointer change.
  - Push while full without a simultaneous pop: byte dropped, overrun pulses, FIFO state unchanged.
  - Push while full with a simultaneous pop: both succeed, level unchanged, no overrun.
  - Push and pop on a non-full, non-empty FIFO: level unchanged.
- cts_n is registered from the next-state level, so it changes in the same cycle as level.
- At most one of frame_err, overrun and timeout pulses per cycle.
- Asserting reset_n=0 mid-frame clears everything asynchronously. The next frame is recognised only after a fresh start bit.

Optional Feature:
- Macro: CHAMELEON_USART_RX_PARITY_EN.
- Defined:
  - After DATA the FSM enters PARITY. On se it checks even parity (^{shreg,rxd} must be 0) and stores the result, then goes to STOP.
  - If parity failed, the STOP-state good-stop case also discards the byte and pulses frame_err.
  - Frame length is 11 serial clocks.
- Undefined: no PARITY state, 10-clock frame, no parity logic.

Decomposition:
- Package chameleon_usart_pkg:
  - FSM state typedef (IDLE, DATA, PARITY, STOP).
  - Constants DATA_BITS=8, START_LEVEL=0, STOP_LEVEL=1.
- Sub-module chameleon_sync_fifo:
  - Parameterised width/depth, first-word fall-through.
  - Push/pop, full/empty and level outputs.
  - Full-with-simultaneous-pop rule implemented inside it.
- The synchroniser, FSM, timer and error pulses live in the top.

Test Plan:
- Send 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) at serial_clk = clk/16 -> rd_valid rises the cycle after the stop-bit se, rd_data=0xA5, level=1; rd_en for one cycle -> rd_valid=0, level=0.
- Send 0x3C with stop bit 0 -> frame_err pulses exactly 1 cycle, level stays 0. A following good 0x11 is received correctly.
- Send 5 bytes 0x01..0x05 with rd_en=0 (FIFO_AW=2) -> cts_n=1 after the 3rd byte; the 5th byte gives an overrun pulse; pops return 0x01..0x04.
- FIFO full; assert rd_en in the exact cycle the 5th byte is pushed -> no overrun, level stays 4, last pop sequence ends in 0x05.
- Stop serial_clk after the 4th data bit -> timeout pulses after 1023 idle clk cycles. The next full frame 0x7E is received intact.
- Assert reset_n low mid-frame for 2 cycles -> all outputs at reset values immediately; resume clocking the same frame -> no byte pushed until a new start bit is sent.
